instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage directly upstream of the decoder and immediate generator. Holds the fetch PC and issues word requests to instruction memory over a request/grant/response handshake. Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready interface. Handles control-transfer redirects by flushing buffered and in-flight instructions.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; must be word aligned.
- `FIFO_DEPTH`, default `2`: instruction buffer entries; must be 2 or 4.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: request word address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response data valid.
- `imem_rdata` in 32: response instruction word.
- `redirect_valid` in 1: branch/jump taken, one-cycle pulse.
- `redirect_pc` in 32: redirect target.
- `inst_valid` out 1: `inst_code` and `inst_pc` valid.
- `inst_ready` in 1: decode consumes the instruction.
- `inst_code` out 32: instruction to decoder and immediate generator.
- `inst_pc` out 32: PC of `inst_code`.
- `misalign_fault` out 1: present only when `FETCH_MISALIGN_CHECK_EN` is defined.

## Operation
- State machine:
  - IDLE: no request.
  - REQ: `imem_req`=1, `imem_addr`=`fetch_pc`.
  - WAIT: one request outstanding, `imem_req`=0.
- At most one outstanding request.
- `space` = `FIFO_DEPTH` − occupancy − (1 if WAIT).
- IDLE→REQ when `space` > 0. REQ holds `imem_addr` stable until `imem_gnt`, except on redirect.
- REQ with `imem_gnt`: `fetch_pc` += 4 (32-bit wrap, `32'hFFFF_FFFC`→0), then →WAIT.
- WAIT with `imem_rvalid`:
  - Push {`imem_rdata`, request PC} unless the `discard` flag is set.
  - If `discard` is set, clear it and drop the data.
  - Next state is REQ if `space` > 0 after the push, else IDLE.
- Redirect has highest priority, in any state:
  - Flush the FIFO and load `fetch_pc` from `redirect_pc`.
  - Next state: REQ, or WAIT if a request is still outstanding.
  - Set `discard` if in WAIT without same-cycle `imem_rvalid`, or in REQ with same-cycle `imem_gnt`.
  - Drop any same-cycle response. A same-cycle decode pop is void.
- Redirect while `discard` is already set: `discard` stays set, so exactly one response is dropped.
- FIFO pop on `inst_valid & inst_ready`. Simultaneous push and pop is allowed at any occupancy.
- Reset values:
  - Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst_code`=0, `inst_pc`=0, `misalign_fault`=0.
  - State: IDLE, FIFO empty, `discard`=0, `fetch_pc`=`RESET_PC`.
- Reset asserted mid-transaction: all state returns to reset values. The memory side must also be reset; no outstanding response is tracked.

## Timing
- `rst_n` deasserted before edge N: `imem_req`=1 from cycle N+1.
- `imem_rvalid` at cycle T: `inst_valid` at T+1 (registered FIFO output).
- Peak throughput: one instruction per 2 cycles (REQ, WAIT) with 1-cycle memory.
- Redirect at cycle T:
  - `inst_valid`=0 at T+1.
  - `imem_addr`=`redirect_pc` with `imem_req`=1 at T+1 if no request is outstanding.
  - Otherwise the request is issued the cycle after the dropped response.
- `inst_code` and `inst_pc` are stable while `inst_valid` & !`inst_ready`.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]` ≠ 0 still flushes, then sets sticky `misalign_fault`=1 and forces IDLE.
  - No requests are issued until a redirect with an aligned target, which clears the fault.
- `FETCH_MISALIGN_CHECK_EN` undefined:
  - The port is absent.
  - `redirect_pc[1:0]` is ignored (treated as 0); fetch continues.

## Structure
- Shared package `riscv_pkg`:
  - `fetch_state_t` enum (IDLE, REQ, WAIT).
  - `fetch_entry_t` struct {`code`[31:0], `pc`[31:0]}.
  - `INST_BYTES`=4.
  - `NOP_INST`=`32'h0000_0013`.
- Sub-module `fetch_fifo`:
  - Parameterised depth; push, pop and flush.
  - Registered head output; `count` output.
  - Flush has priority over push and pop.

## Test plan
- Reset release with 1-cycle memory returning `32'h0000_0013`, 0x4, 0x8 → `inst_pc` sequence 0x0, 0x4, 0x8 with codes in order; `inst_valid` first at cycle 4.
- `inst_ready`=0 held for 10 cycles → after `FIFO_DEPTH` entries, `imem_req` stays 0; no entry lost or overwritten when ready returns.
- `redirect_pc`=0x100 while in WAIT, response `32'hDEAD_BEEF` arrives 3 cycles later → data dropped; next `inst_pc`=0x100.
- Redirect in the same cycle as `imem_gnt` for 0x8 → 0x8 response discarded; first valid `inst_pc`=redirect target.
- `fetch_pc`=`32'hFFFF_FFFC` granted → next `imem_addr`=0x0.
- With `FETCH_MISALIGN_CHECK_EN`, `redirect_pc`=0x102 → `misalign_fault`=1 and `imem_req`=0; a later redirect to 0x200 clears the fault and fetches 0x200.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch types and constants
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] code;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam int unsigned INST_BYTES = 4;
   localparam logic [31:0] NOP_INST   = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - shifting instruction buffer with registered head entry
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  fetch_entry_t  din,
   output fetch_entry_t  head,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem [DEPTH];
   logic [CW-1:0] wr_idx;

   // Entries shift toward slot 0 on pop, so the head is always a flop.
   assign wr_idx = pop ? count - CW'(1) : count;
   assign head   = mem[0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (pop) mem[i] <= mem[i+1];
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (push && i == int'(wr_idx)) mem[i] <= din;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, imem handshake and redirect flush; option FETCH_MISALIGN_CHECK_EN
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_code,
   output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        misalign_fault
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_t  state;
   fetch_state_t  redirect_state;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic [31:0]   target;
   logic          discard;
   logic          push;
   logic          pop;
   logic          outstanding;
   logic          fault;
   logic          bad_target;
   logic [CW-1:0] count;
   fetch_entry_t  head;
   int            space;
   int            space_after;

   assign imem_req   = (state == REQ);
   assign imem_addr  = fetch_pc;
   assign inst_valid = (count != '0);
   assign inst_code  = head.code;
   assign inst_pc    = head.pc;
   assign target     = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
   assign bad_target     = (redirect_pc[1:0] != 2'b00);
   assign misalign_fault = fault;

   always_ff @(posedge clk) begin
      if (!rst_n) fault <= 1'b0;
      else if (redirect_valid) fault <= bad_target;
   end
`else
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^redirect_pc[1:0];
   assign bad_target     = 1'b0;
   assign fault          = 1'b0;
`endif

   always_comb begin
      pop         = inst_valid && inst_ready && !redirect_valid;
      push        = (state == WAIT) && imem_rvalid && !discard && !redirect_valid;
      space       = FIFO_DEPTH - int'(count) - ((state == WAIT) ? 1 : 0);
      space_after = FIFO_DEPTH - (int'(count) + (push ? 1 : 0) - (pop ? 1 : 0));
      // A request still in flight after this edge must have its response dropped.
      outstanding = ((state == WAIT) && !imem_rvalid) || ((state == REQ) && imem_gnt);
      if (outstanding)     redirect_state = WAIT;
      else if (bad_target) redirect_state = IDLE;
      else                 redirect_state = REQ;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         discard  <= 1'b0;
      end else if (redirect_valid) begin
         state    <= redirect_state;
         fetch_pc <= target;
         discard  <= outstanding;
      end else begin
         case (state)
            IDLE: if (space > 0 && !fault) state <= REQ;
            REQ: begin
               if (imem_gnt) begin
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + INST_BYTES;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  discard <= 1'b0;
                  state   <= (space_after > 0 && !fault) ? REQ : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .din   ('{code: imem_rdata, pc: req_pc}),
      .head  (head),
      .count (count)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized fetch bench with sequential-stream reference model
module tb_instr_fetch_unit;
   import riscv_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_code;
   logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_fault;
`endif

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_code      (inst_code),
      .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .misalign_fault (misalign_fault)
`endif
   );

   int checks   = 0;
   int failures = 0;

   int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
   bit force_gnt = 0, rd_v = 0, rst_req = 0;
   logic [31:0] rd_pc = '0;

   bit          busy = 0;
   int          delay = 0;
   logic [31:0] raddr = '0;
   bit          p_gnt = 0, p_rvalid = 0, p_rst = 0, p_hold = 0;
   logic [31:0] p_addr = '0, p_code = '0, p_pc = '0;
   logic [31:0] exp_pc = RESET_PC, exp_req = RESET_PC;
   int          pops = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Low addresses return the boot pattern NOP, 0x4, 0x8; everything else a hash.
   function automatic logic [31:0] code_of(input logic [31:0] a);
      if (a < 32'h10) return (a == 32'h0) ? NOP_INST : a;
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic tick();
      @(negedge clk);
      if (!p_rst) begin
         busy    = 0;
         exp_pc  = RESET_PC;
         exp_req = RESET_PC;
      end else begin
         if (p_rvalid) busy = 0;
         else if (busy) delay--;
         if (p_gnt) begin
            busy  = 1;
            raddr = p_addr;
            delay = int'($urandom_range(lat_max, lat_min)) - 1;
         end
      end
      rst_n          = rst_req;
      imem_gnt       = imem_req && (force_gnt || int'($urandom_range(99)) < gnt_pct);
      imem_rvalid    = busy && delay == 0;
      imem_rdata     = imem_rvalid ? code_of(raddr) : $urandom();
      inst_ready     = int'($urandom_range(99)) < rdy_pct;
      redirect_valid = rd_v;
      redirect_pc    = rd_v ? rd_pc : $urandom();
      force_gnt      = 0;
      rd_v           = 0;
      if (p_rst) begin
         if (busy) check("one_outstanding", 32'(imem_req), 32'd0);
         if (p_hold) begin
            check("hold_valid", 32'(inst_valid), 32'd1);
            check("hold_code", inst_code, p_code);
            check("hold_pc", inst_pc, p_pc);
         end
         if (imem_req && imem_gnt) begin
            check("req_addr", imem_addr, exp_req);
            exp_req += 32'd4;
         end
         if (inst_valid && inst_ready && !redirect_valid) begin
            check("pop_pc", inst_pc, exp_pc);
            check("pop_code", inst_code, code_of(exp_pc));
            exp_pc += 32'd4;
            pops++;
         end
         if (redirect_valid) begin
            exp_pc  = redirect_pc & ~32'd3;
            exp_req = redirect_pc & ~32'd3;
         end
      end
      p_hold   = rst_n && inst_valid && !inst_ready && !redirect_valid;
      p_code   = inst_code;
      p_pc     = inst_pc;
      p_gnt    = imem_gnt;
      p_rvalid = imem_rvalid;
      p_addr   = imem_addr;
      p_rst    = rst_n;
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(imem_req && imem_gnt) && n < 60);
      if (!(imem_req && imem_gnt)) check(tag, 32'd0, 32'd1);
   endtask

   initial begin
      int base;
      int n;
      rst_n = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
      redirect_valid = 0; redirect_pc = '0; inst_ready = 0;

      repeat (3) tick();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_code", inst_code, 32'd0);
      check("rst_pc", inst_pc, 32'd0);

      // Boot: release before edge N, request in N+1, first instruction in N+3.
      rst_req = 1;
      tick();
      tick();
      check("boot_req", 32'(imem_req), 32'd1);
      check("boot_addr", imem_addr, RESET_PC);
      tick();
      check("boot_valid_early", 32'(inst_valid), 32'd0);
      tick();
      check("boot_valid", 32'(inst_valid), 32'd1);
      check("boot_pc0", inst_pc, RESET_PC);
      repeat (6) tick();
      check("boot_three_pops", 32'(pops >= 3), 32'd1);

      base = pops;
      repeat (20) tick();
      check("peak_throughput", 32'((pops - base) >= 9 && (pops - base) <= 10), 32'd1);

      rdy_pct = 0;
      repeat (10) tick();
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_valid", 32'(inst_valid), 32'd1);
      rdy_pct = 100;
      repeat (10) tick();

      // Redirect while a slow response is outstanding.
      lat_min = 4; lat_max = 4;
      wait_grant("rdw_grant_timeout");
      rd_v = 1; rd_pc = 32'h0000_0100;
      tick();
      tick();
      check("rdw_valid", 32'(inst_valid), 32'd0);
      check("rdw_req", 32'(imem_req), 32'd0);
      base = pops;
      repeat (30) tick();
      check("rdw_progress", 32'(pops > base), 32'd1);

      // Redirect in the same cycle the request is granted.
      lat_min = 1; lat_max = 1; gnt_pct = 0;
      n = 0;
      do begin tick(); n++; end while (!imem_req && n < 60);
      check("rdg_req_seen", 32'(imem_req), 32'd1);
      force_gnt = 1; rd_v = 1; rd_pc = 32'h0000_0400;
      tick();
      gnt_pct = 100;
      tick();
      check("rdg_valid", 32'(inst_valid), 32'd0);
      check("rdg_req", 32'(imem_req), 32'd0);
      base = pops;
      repeat (20) tick();
      check("rdg_progress", 32'(pops > base), 32'd1);

      // Address wrap at the top of memory.
      rd_v = 1; rd_pc = 32'hFFFF_FFF4;
      repeat (30) tick();
      check("wrap_pc_low", 32'(exp_pc < 32'h40 && pops > base + 4), 32'd1);

`ifdef FETCH_MISALIGN_CHECK_EN
      rd_v = 1; rd_pc = 32'h0000_0102;
      repeat (7) tick();
      check("mis_fault", 32'(misalign_fault), 32'd1);
      check("mis_req", 32'(imem_req), 32'd0);
      rd_v = 1; rd_pc = 32'h0000_0200;
      tick();
      tick();
      check("mis_clear", 32'(misalign_fault), 32'd0);
      check("mis_req2", 32'(imem_req), 32'd1);
      check("mis_addr", imem_addr, 32'h0000_0200);
      repeat (10) tick();
`endif

      // Reset in the middle of traffic.
      lat_min = 3; lat_max = 3;
      repeat (5) tick();
      rst_req = 0;
      tick();
      tick();
      check("mid_rst_req", 32'(imem_req), 32'd0);
      check("mid_rst_valid", 32'(inst_valid), 32'd0);
      check("mid_rst_addr", imem_addr, RESET_PC);
      rst_req = 1;
      repeat (20) tick();

      gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 4;
      base = pops;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 4) begin
            rd_v  = 1;
            rd_pc = $urandom();
`ifdef FETCH_MISALIGN_CHECK_EN
            rd_pc[1:0] = 2'b00;
`endif
         end
         tick();
      end
      check("random_progress", 32'((pops - base) > 200), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
